bram_debug_sequencer: RTL and testbench

- Synthesizable sequencer that drives the debug port (A2/WD2/WE2/RD2) of NUM_CH block RAMs in the RV32 pipeline SoC.
- Replaces the fixed load/run/dump sequence with command-driven operations:
  - LOAD streams words into a chosen RAM.
  - DUMP streams words back out with backpressure.
  - RUN pulses core reset, then waits a fixed number of cycles.
- Sits between a host stream interface (UART/JTAG bridge or bench) and the core's debug RAM ports.

---
 rtl/bram_debug_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_bram_debug_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_debug_sequencer.sv
`timescale 1ns/1ps
// bram_debug_sequencer
// Command-driven sequencer for the debug port (A2/WD2/WE2/RD2) of NUM_CH block
// RAMs. A host issues LOAD (stream words into a RAM), DUMP (stream words back
// out with backpressure) or RUN (pulse core reset, then wait a fixed window).
//
// Ports:
//   CPU_CLK, CPU_RST_N              clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only when idle)
//   cmd_op, cmd_ch, cmd_len         00 LOAD, 01 DUMP, 10 RUN; channel; length (0 = WORDS)
//   ld_valid/ld_ready, ld_data      load-data stream in
//   du_valid/du_ready, du_data/addr dump-data stream out
//   dbg_a2, dbg_wd2, dbg_we2        per-channel debug address/data/byte enables
//   dbg_rd2                         per-channel debug read data
//   core_rst                        active-high reset to the core
//   busy, done, err                 status; done/err are one-cycle pulses
module bram_debug_sequencer #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WORDS      = 4096,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RST_CYCLES = 5,
    parameter int unsigned RUN_CYCLES = 200000,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned LEN_W     = $clog2(WORDS) + 1,
    localparam int unsigned BE_W      = DATA_W / 8
) (
    input  logic                       CPU_CLK,
    input  logic                       CPU_RST_N,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [CH_W-1:0]            cmd_ch,
    input  logic [LEN_W-1:0]           cmd_len,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [DATA_W-1:0]          ld_data,
    output logic                       du_valid,
    input  logic                       du_ready,
    output logic [DATA_W-1:0]          du_data,
    output logic [ADDR_W-1:0]          du_addr,
    output logic [NUM_CH*ADDR_W-1:0]   dbg_a2,
    output logic [NUM_CH*DATA_W-1:0]   dbg_wd2,
    output logic [NUM_CH*BE_W-1:0]     dbg_we2,
    input  logic [NUM_CH*DATA_W-1:0]   dbg_rd2,
    output logic                       core_rst,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned WAIT_W   = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam int unsigned RUN_MAX  = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
    localparam int unsigned RUN_W    = $clog2(RUN_MAX + 1);
    localparam int unsigned CH_SLOTS = 1 << CH_W;
    // Bit c set when channel code c addresses a real RAM.
    localparam logic [CH_SLOTS-1:0] CH_OK = CH_SLOTS'((64'd1 << NUM_CH) - 64'd1);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_DUMP = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_D_ISSUE, S_D_WAIT, S_D_OUT, S_R_RST, S_R_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d, len_eff;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                done_pend_q, done_pend_d;

    logic                cmd_ready_q, cmd_ready_d, ld_ready_q, ld_ready_d;
    logic                du_valid_q, du_valid_d, core_rst_q, core_rst_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [DATA_W-1:0]   du_data_q, du_data_d;
    logic [ADDR_W-1:0]   du_addr_q, du_addr_d;
    logic [NUM_CH*ADDR_W-1:0] dbg_a2_q, dbg_a2_d;
    logic [NUM_CH*DATA_W-1:0] dbg_wd2_q, dbg_wd2_d;
    logic [NUM_CH*BE_W-1:0]   dbg_we2_q, dbg_we2_d;

    logic                drv_a, drv_w;
    logic [ADDR_W-1:0]   a_val;
    logic [DATA_W-1:0]   wd_val;
    logic [DATA_W-1:0]   rd_sel;

    // Clamp requested length into 1..WORDS (0 means a full RAM).
    always_comb begin
        len_eff = cmd_len;
        if (cmd_len == '0 || cmd_len > LEN_W'(WORDS)) begin
            len_eff = LEN_W'(WORDS);
        end
    end

    // Read data of the latched channel.
    always_comb begin
        rd_sel = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_q == CH_W'(c)) begin
                rd_sel = dbg_rd2[c*DATA_W +: DATA_W];
            end
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wait_d      = wait_q;
        run_d       = run_q;
        done_pend_d = 1'b0;
        du_valid_d  = du_valid_q;
        du_data_d   = du_data_q;
        du_addr_d   = du_addr_q;
        core_rst_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        drv_a       = 1'b0;
        drv_w       = 1'b0;
        a_val       = '0;
        wd_val      = '0;

        unique case (state_q)
            S_IDLE: begin
                // A LOAD finishes with done one cycle after its last write.
                done_d = done_pend_q;
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_op == 2'b11 || (cmd_op != OP_RUN && !CH_OK[cmd_ch])) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        ch_d   = cmd_ch;
                        len_d  = len_eff;
                        cnt_d  = '0;
                        addr_d = '0;
                        run_d  = '0;
                        wait_d = '0;
                        case (cmd_op)
                            OP_LOAD: state_d = S_LOAD;
                            OP_DUMP: begin
                                state_d = S_D_ISSUE;
                                drv_a   = 1'b1;
                            end
                            default: begin
                                state_d    = S_R_RST;
                                core_rst_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    drv_w  = 1'b1;
                    a_val  = addr_q;
                    wd_val = ld_data;
                    addr_d = addr_q + ADDR_W'(BE_W);
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d     = S_IDLE;
                        done_pend_d = 1'b1;
                    end
                end
            end
            S_D_ISSUE: begin
                // Keep the address stable while the read is in flight.
                drv_a   = 1'b1;
                a_val   = addr_q;
                wait_d  = '0;
                state_d = S_D_WAIT;
            end
            S_D_WAIT: begin
                if (wait_q == WAIT_W'(RD_LAT - 1)) begin
                    du_data_d  = rd_sel;
                    du_addr_d  = addr_q;
                    du_valid_d = 1'b1;
                    state_d    = S_D_OUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    drv_a  = 1'b1;
                    a_val  = addr_q;
                end
            end
            S_D_OUT: begin
                if (du_ready) begin
                    du_valid_d = 1'b0;
                    addr_d     = addr_q + ADDR_W'(BE_W);
                    cnt_d      = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_D_ISSUE;
                        drv_a   = 1'b1;
                        a_val   = addr_q + ADDR_W'(BE_W);
                    end
                end
            end
            S_R_RST: begin
                if (run_q == RUN_W'(RST_CYCLES - 1)) begin
                    run_d   = '0;
                    state_d = S_R_WAIT;
                end else begin
                    run_d      = run_q + RUN_W'(1);
                    core_rst_d = 1'b1;
                end
            end
            S_R_WAIT: begin
                if (run_q == RUN_W'(RUN_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        ld_ready_d  = (state_d == S_LOAD);

        // Only the selected channel is driven; all others stay at zero.
        dbg_a2_d  = '0;
        dbg_wd2_d = '0;
        dbg_we2_d = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_d == CH_W'(c)) begin
                dbg_a2_d[c*ADDR_W +: ADDR_W]  = (drv_a || drv_w) ? a_val : '0;
                dbg_wd2_d[c*DATA_W +: DATA_W] = drv_w ? wd_val : '0;
                dbg_we2_d[c*BE_W +: BE_W]     = drv_w ? '1 : '0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wait_q      <= '0;
            run_q       <= '0;
            done_pend_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            ld_ready_q  <= 1'b0;
            du_valid_q  <= 1'b0;
            du_data_q   <= '0;
            du_addr_q   <= '0;
            core_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dbg_a2_q    <= '0;
            dbg_wd2_q   <= '0;
            dbg_we2_q   <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wait_q      <= wait_d;
            run_q       <= run_d;
            done_pend_q <= done_pend_d;
            cmd_ready_q <= cmd_ready_d;
            ld_ready_q  <= ld_ready_d;
            du_valid_q  <= du_valid_d;
            du_data_q   <= du_data_d;
            du_addr_q   <= du_addr_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            dbg_a2_q    <= dbg_a2_d;
            dbg_wd2_q   <= dbg_wd2_d;
            dbg_we2_q   <= dbg_we2_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign ld_ready  = ld_ready_q;
    assign du_valid  = du_valid_q;
    assign du_data   = du_data_q;
    assign du_addr   = du_addr_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_a2    = dbg_a2_q;
    assign dbg_wd2   = dbg_wd2_q;
    assign dbg_we2   = dbg_we2_q;

endmodule

// File: tb/tb_bram_debug_sequencer.sv
`timescale 1ns/1ps
// Bench for bram_debug_sequencer: three channels (code 3 is an illegal
// channel), 8-word RAMs with one-cycle read latency, short RUN window.
module tb_bram_debug_sequencer;

    localparam int NCH  = 3;
    localparam int WD   = 8;
    localparam int RSTC = 5;
    localparam int RUNC = 20;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_ch;
    logic [3:0]  cmd_len;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_data;
    logic        du_valid, du_ready;
    logic [31:0] du_data, du_addr;
    logic [95:0] dbg_a2, dbg_wd2, dbg_rd2;
    logic [11:0] dbg_we2;
    logic        core_rst, busy, done, err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ram     [NCH][WD];
    logic [31:0] ref_mem [NCH][WD];

    bram_debug_sequencer #(
        .NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .WORDS(WD), .RD_LAT(1),
        .RST_CYCLES(RSTC), .RUN_CYCLES(RUNC)
    ) dut (
        .CPU_CLK(clk), .CPU_RST_N(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ch(cmd_ch), .cmd_len(cmd_len),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .du_valid(du_valid), .du_ready(du_ready), .du_data(du_data), .du_addr(du_addr),
        .dbg_a2(dbg_a2), .dbg_wd2(dbg_wd2), .dbg_we2(dbg_we2), .dbg_rd2(dbg_rd2),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment RAMs: byte-enabled write, one-cycle registered read.
    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            dbg_rd2[c*32 +: 32] <= ram[c][dbg_a2[c*32+2 +: 3]];
            for (int b = 0; b < 4; b++) begin
                if (dbg_we2[c*4+b]) ram[c][dbg_a2[c*32+2 +: 3]][b*8 +: 8] <= dbg_wd2[c*32+b*8 +: 8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] lane32(input int ch, input logic [31:0] v);
        return 128'(v) << (ch * 32);
    endfunction

    function automatic logic [127:0] lane4(input int ch, input logic [3:0] v);
        return 128'(v) << (ch * 4);
    endfunction

    function automatic int eff_len(input int l);
        return (l == 0 || l > WD) ? WD : l;
    endfunction

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Command inputs wiggle only while the sequencer is not accepting.
    task automatic garbage();
        cmd_valid = !cmd_ready && ($urandom_range(0, 1) == 1);
        cmd_op    = 2'($urandom);
        cmd_ch    = 2'($urandom);
        cmd_len   = 4'($urandom);
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0;
        ld_valid  = 1'b0;
        du_ready  = 1'b0;
    endtask

    task automatic issue_cmd(input int op, input int ch, input int len);
        check_eq("cmd_ready_pre", 128'(cmd_ready), 128'(1));
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_ch    = 2'(ch);
        cmd_len   = 4'(len);
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic do_load(input int ch, input int clen, input bit directed);
        int L, idx;
        bit pend, fin, tg;
        logic [31:0] pa, pd, last_a;
        L = eff_len(clen);
        idx = 0; pend = 0; fin = 0; tg = 1; pa = 0; pd = 0; last_a = 0;
        issue_cmd(0, ch, clen);
        for (int k = 0; k < L * 8 + 8 && !fin; k++) begin
            check_eq("ld_we2", 128'(dbg_we2), pend ? lane4(ch, 4'hF) : 128'(0));
            check_eq("ld_a2",  128'(dbg_a2),  pend ? lane32(ch, pa) : 128'(0));
            check_eq("ld_wd2", 128'(dbg_wd2), pend ? lane32(ch, pd) : 128'(0));
            if (idx == L && !pend) begin
                check_eq("ld_done", 128'(done), 128'(1));
                check_eq("ld_err",  128'(err),  128'(0));
                check_eq("ld_busy_end", 128'(busy), 128'(0));
                fin = 1;
            end else begin
                check_eq("ld_done_early", 128'(done), 128'(0));
                check_eq("ld_ready", 128'(ld_ready), 128'(idx < L));
                check_eq("ld_busy", 128'(busy), 128'(idx < L));
            end
            if (pend) last_a = pa;
            pend = 0;
            if (!fin) begin
                if (directed && idx < L) begin
                    ld_valid = tg;
                    tg = !tg;
                    ld_data = 32'h11111111 * 32'(idx + 1);
                end else begin
                    ld_valid = ($urandom_range(0, 2) != 0);
                    ld_data  = $urandom;
                end
                if (ld_valid && ld_ready && idx < L) begin
                    pend = 1;
                    pa = 32'(idx * 4);
                    pd = ld_data;
                    ref_mem[ch][idx] = ld_data;
                    idx++;
                end
                du_ready = ($urandom_range(0, 1) == 1);
                garbage();
                cyc();
            end
        end
        check_eq("ld_finished", 128'(fin), 128'(1));
        check_eq("ld_last_addr", 128'(last_a), 128'(L * 4 - 4));
        idle_inputs();
    endtask

    task automatic do_dump(input int ch, input int clen, input bit rnd,
                           input int stall_word, input int rst_word);
        int L, i, vc;
        bit fin;
        L = eff_len(clen);
        i = 0; vc = 0; fin = 0;
        issue_cmd(1, ch, clen);
        for (int k = 0; k < L * 16 + 8 && !fin; k++) begin
            check_eq("du_we2", 128'(dbg_we2), 128'(0));
            check_eq("du_wd2", 128'(dbg_wd2), 128'(0));
            check_eq("du_a2_other", 128'(dbg_a2) & ~lane32(ch, 32'hFFFF_FFFF), 128'(0));
            if (i == L) begin
                check_eq("du_done", 128'(done), 128'(1));
                check_eq("du_err", 128'(err), 128'(0));
                check_eq("du_valid_end", 128'(du_valid), 128'(0));
                check_eq("du_busy_end", 128'(busy), 128'(0));
                fin = 1;
            end else begin
                check_eq("du_done_early", 128'(done), 128'(0));
                check_eq("du_busy", 128'(busy), 128'(1));
                if (du_valid) begin
                    check_eq("du_data", 128'(du_data), 128'(ref_mem[ch][i]));
                    check_eq("du_addr", 128'(du_addr), 128'(i * 4));
                    if (i == rst_word) begin
                        rst_n = 1'b0;
                        idle_inputs();
                        cyc();
                        rst_n = 1'b1;
                        check_eq("rst_du_valid", 128'(du_valid), 128'(0));
                        check_eq("rst_busy", 128'(busy), 128'(0));
                        check_eq("rst_cmd_ready", 128'(cmd_ready), 128'(1));
                        check_eq("rst_done", 128'(done), 128'(0));
                        cyc();
                        check_eq("rst_done_later", 128'(done), 128'(0));
                        fin = 1;
                    end else begin
                        if (i == stall_word) du_ready = (vc >= 3);
                        else du_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                        if (du_ready) begin
                            i++;
                            vc = 0;
                        end else begin
                            vc++;
                        end
                    end
                end else begin
                    du_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
                end
            end
            if (!fin) begin
                ld_valid = ($urandom_range(0, 1) == 1);
                ld_data  = $urandom;
                garbage();
                cyc();
            end
        end
        check_eq("du_finished", 128'(fin), 128'(1));
        idle_inputs();
    endtask

    task automatic do_run();
        issue_cmd(2, 0, 0);
        for (int k = 1; k <= RSTC + RUNC + 1; k++) begin
            check_eq("run_core_rst", 128'(core_rst), 128'(k <= RSTC));
            check_eq("run_busy", 128'(busy), 128'(k <= RSTC + RUNC));
            check_eq("run_done", 128'(done), 128'(k == RSTC + RUNC + 1));
            check_eq("run_we2", 128'(dbg_we2), 128'(0));
            check_eq("run_a2", 128'(dbg_a2), 128'(0));
            if (k <= RSTC + RUNC) begin
                ld_valid = ($urandom_range(0, 1) == 1);
                garbage();
                cyc();
            end
        end
        idle_inputs();
    endtask

    task automatic do_illegal(input int op, input int ch);
        issue_cmd(op, ch, 4'($urandom));
        check_eq("ill_done", 128'(done), 128'(1));
        check_eq("ill_err", 128'(err), 128'(1));
        check_eq("ill_busy", 128'(busy), 128'(0));
        check_eq("ill_cmd_ready", 128'(cmd_ready), 128'(1));
        check_eq("ill_we2", 128'(dbg_we2), 128'(0));
        check_eq("ill_a2", 128'(dbg_a2), 128'(0));
        check_eq("ill_ld_ready", 128'(ld_ready), 128'(0));
        cyc();
        check_eq("ill_done_clr", 128'(done), 128'(0));
        check_eq("ill_err_clr", 128'(err), 128'(0));
    endtask

    initial begin
        int r, ch, clen;
        rst_n = 1'b0;
        cmd_op = 2'b00; cmd_ch = 2'b00; cmd_len = 4'd0; ld_data = 32'd0;
        idle_inputs();
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < WD; w++) ref_mem[c][w] = 32'd0;

        cyc();
        cyc();
        check_eq("rst_cmd_ready0", 128'(cmd_ready), 128'(1));
        check_eq("rst_busy0", 128'(busy), 128'(0));
        check_eq("rst_flags0", 128'({ld_ready, du_valid, core_rst, done, err}), 128'(0));
        check_eq("rst_du0", 128'({du_data, du_addr}), 128'(0));
        check_eq("rst_dbg0", 128'(dbg_a2) | 128'(dbg_wd2) | 128'(dbg_we2), 128'(0));
        rst_n = 1'b1;
        cyc();

        do_load(0, 4, 1'b1);
        do_dump(0, 4, 1'b0, 2, -1);
        do_run();

        do_load(1, 0, 1'b0);
        do_load(2, 12, 1'b0);
        do_load(0, 0, 1'b0);

        do_illegal(3, 0);
        do_illegal(0, 3);
        do_illegal(1, 3);

        do_dump(0, 4, 1'b0, -1, 2);
        do_load(0, 2, 1'b0);

        for (int n = 0; n < 30; n++) begin
            r    = int'($urandom_range(0, 9));
            ch   = int'($urandom_range(0, NCH - 1));
            clen = int'($urandom_range(0, 15));
            if (r == 0)      do_illegal(3, ch);
            else if (r == 9) do_illegal(int'($urandom_range(0, 1)), 3);
            else if (r <= 4) do_load(ch, clen, 1'b0);
            else             do_dump(ch, clen, 1'b1, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
